// File: rtl/fibo_seq_engine.sv
// Purpose : one start pulse computes term n of the Fibonacci (0,1) or Lucas (2,1) sequence.
// Latency : start sampled at edge E -> done high in the cycle after edge E+n+1.
// Backpres: none; start is ignored while busy, there is no request queue.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode, n_term request, sequence select (0 Fib, 1 Lucas), term index
//   busy, done          busy while not IDLE, done is a one-cycle result strobe
//   result, zero_flag   registered term n and (result == 0), updated on entry to DONE
//   overflow            sticky carry-out seen during the current/last run
//   dbg_addr, dbg_data  combinational register-file read port
//
// Build option: define FIBO_SAT_EN to saturate sums to all-ones on carry-out;
// otherwise sums wrap mod 2^WIDTH.
module fibo_seq_engine #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = 2,
  parameter int NW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [NW-1:0]    n_term,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             overflow,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  // Register file is sized to the full address space so any dbg_addr is a
  // legal read; entries at NREGS and above are never written and read as 0.
  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD0,
    S_LOAD1,
    S_STEP,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] rf [DEPTH];
  logic [AW-1:0]    ptr;
  logic [NW-1:0]    idx;
  logic [NW-1:0]    n_q;
  logic             mode_q;

  logic [WIDTH-1:0] seed0, seed1;
  logic [AW-1:0]    ptr_m1, ptr_m2, ptr_nxt;
  logic [NW-1:0]    idx_nxt;
  logic [WIDTH:0]   sum_full;
  logic             carry;
  logic [WIDTH-1:0] sum_st;

  assign seed0 = mode_q ? WIDTH'(2) : '0;
  assign seed1 = WIDTH'(1);

  // Circular predecessors of ptr within 0..NREGS-1.
  assign ptr_m1  = (ptr == '0)    ? AW'(NREGS - 1) : ptr - 1'b1;
  assign ptr_m2  = (ptr_m1 == '0) ? AW'(NREGS - 1) : ptr_m1 - 1'b1;
  assign ptr_nxt = (ptr == AW'(NREGS - 1)) ? '0 : ptr + 1'b1;
  assign idx_nxt = idx + 1'b1;

  assign sum_full = {1'b0, rf[ptr_m1]} + {1'b0, rf[ptr_m2]};
  assign carry    = sum_full[WIDTH];

`ifdef FIBO_SAT_EN
  // A saturated operand is all-ones, so any later non-zero addend carries
  // out again and the result stays pinned at all-ones.
  assign sum_st = carry ? '1 : sum_full[WIDTH-1:0];
`else
  assign sum_st = sum_full[WIDTH-1:0];
`endif

  assign dbg_data = rf[dbg_addr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD0;
      S_LOAD0: state_nxt = (n_q == '0)       ? S_DONE : S_LOAD1;
      S_LOAD1: state_nxt = (n_q == NW'(1))   ? S_DONE : S_STEP;
      S_STEP:  if (idx_nxt == n_q) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath: register file, run context, result and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      ptr       <= '0;
      idx       <= '0;
      n_q       <= '0;
      mode_q    <= 1'b0;
      result    <= '0;
      zero_flag <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q      <= n_term;
            mode_q   <= mode;
            overflow <= 1'b0;
          end
        end
        S_LOAD0: begin
          rf[0] <= seed0;
          if (n_q == '0) begin
            result    <= seed0;
            zero_flag <= (seed0 == '0);
          end
        end
        S_LOAD1: begin
          rf[1] <= seed1;
          idx   <= NW'(1);
          ptr   <= AW'(2);
          if (n_q == NW'(1)) begin
            result    <= seed1;
            zero_flag <= (seed1 == '0);
          end
        end
        S_STEP: begin
          rf[ptr] <= sum_st;
          ptr     <= ptr_nxt;
          idx     <= idx_nxt;
          if (carry) overflow <= 1'b1;
          if (idx_nxt == n_q) begin
            result    <= sum_st;
            zero_flag <= (sum_st == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
